// File: rtl/vedic_mul_pkg.sv
// vedic_mul_pkg: shared constants, helpers and lane-level types for the
// pipelined Vedic multiplier.
//   VEDIC_MUL_LATENCY : cycles from accepted operand beat to out_valid.
//   vedic_half()      : half operand width used by the partial-product split.
//   vedic_mul_req_t   : operand beat bundle for lane wiring at the default widths.
package vedic_mul_pkg;

    localparam int unsigned VEDIC_MUL_LATENCY   = 3;
    localparam int unsigned VEDIC_MUL_WIDTH     = 16;
    localparam int unsigned VEDIC_MUL_TAG_WIDTH = 4;

    function automatic int unsigned vedic_half(input int unsigned width);
        return width / 2;
    endfunction

    // 'signed' is a reserved word, so the mode bit is called is_signed.
    typedef struct packed {
        logic [VEDIC_MUL_WIDTH-1:0]     a;
        logic [VEDIC_MUL_WIDTH-1:0]     b;
        logic                           is_signed;
        logic [VEDIC_MUL_TAG_WIDTH-1:0] tag;
    } vedic_mul_req_t;

endpackage

// File: rtl/vedic_mul_unsigned_nbits.sv
// vedic_mul_unsigned_nbits: combinational N x N unsigned Vedic multiplier.
// Splits each operand into halves, recurses on the four half products and
// merges them with ripple-carry adders; 4-bit operands form the base case.
//   a_i : multiplicand (N bits)
//   b_i : multiplier   (N bits)
//   p_o : product      (2N bits)
module vedic_mul_unsigned_nbits
    import vedic_mul_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    if (N <= 4) begin : g_base
        assign p_o = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
    end else begin : g_rec
        localparam int unsigned H = vedic_half(N);

        logic [N-1:0]   ll, lh, hl, hh;
        logic [2*N-1:0] mid;

        function automatic logic [2*N-1:0] rca(input logic [2*N-1:0] x,
                                               input logic [2*N-1:0] y);
            logic           c;
            logic [2*N-1:0] s;
            c = 1'b0;
            for (int i = 0; i < 2 * N; i++) begin
                s[i] = x[i] ^ y[i] ^ c;
                c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
            end
            return s;
        endfunction

        vedic_mul_unsigned_nbits #(.N(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
        vedic_mul_unsigned_nbits #(.N(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[N-1:H]), .p_o(lh));
        vedic_mul_unsigned_nbits #(.N(H)) u_hl (.a_i(a_i[N-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
        vedic_mul_unsigned_nbits #(.N(H)) u_hh (.a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(hh));

        // Cross-term sum needs N+1 bits; the wider adder keeps the carry.
        assign mid = rca({{N{1'b0}}, lh}, {{N{1'b0}}, hl});
        assign p_o = rca({hh, ll}, mid << H);
    end

endmodule

// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe: three-stage pipelined Vedic multiplier with valid/ready
// handshake and pass-through tag. One global stall domain: every stage holds
// when the output is valid and not accepted.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand beat handshake
//   in_a, in_b           : operands (WIDTH bits)
//   in_signed            : two's-complement mode (only with VEDIC_MUL_SIGNED_EN)
//   in_tag               : opaque tag returned with the result
//   out_valid/out_ready  : result handshake
//   out_z, out_tag       : 2*WIDTH product and its tag
// Build option: define VEDIC_MUL_SIGNED_EN to honour in_signed; otherwise all
// operands are treated as unsigned and the negation logic is absent.
module vedic_mul_pipe
    import vedic_mul_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_signed,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_z,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int unsigned HALF = vedic_half(WIDTH);

    logic adv;

    // S1: operand magnitudes
    logic                 s1_valid_q;
    logic [WIDTH-1:0]     s1_a_d, s1_b_d, s1_a_q, s1_b_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;

    // S2: partial products
    logic                 s2_valid_q;
    logic [WIDTH-1:0]     ll_d, lh_d, hl_d, hh_d;
    logic [WIDTH-1:0]     ll_q, lh_q, hl_q, hh_q;
    logic [TAG_WIDTH-1:0] s2_tag_q;

    // S3: combined product
    logic                 s3_valid_q;
    logic [WIDTH:0]       mid;
    logic [2*WIDTH-1:0]   z_mag;
    logic [2*WIDTH-1:0]   s3_z_d, s3_z_q;
    logic [TAG_WIDTH-1:0] s3_tag_q;

    assign adv = !s3_valid_q || out_ready;
    // Reads 1 while in reset; the reset branch below still refuses the beat.
    assign in_ready = adv || !rst_n;

`ifdef VEDIC_MUL_SIGNED_EN
    logic s1_neg_d, s1_neg_q, s2_neg_q;

    always_comb begin
        s1_a_d   = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        s1_b_d   = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        s1_neg_d = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    end
`else
    logic unused_in_signed;
    assign unused_in_signed = in_signed;

    always_comb begin
        s1_a_d = in_a;
        s1_b_d = in_b;
    end
`endif

    vedic_mul_unsigned_nbits #(.N(HALF)) u_mul_ll (
        .a_i(s1_a_q[HALF-1:0]), .b_i(s1_b_q[HALF-1:0]), .p_o(ll_d)
    );
    vedic_mul_unsigned_nbits #(.N(HALF)) u_mul_lh (
        .a_i(s1_a_q[HALF-1:0]), .b_i(s1_b_q[WIDTH-1:HALF]), .p_o(lh_d)
    );
    vedic_mul_unsigned_nbits #(.N(HALF)) u_mul_hl (
        .a_i(s1_a_q[WIDTH-1:HALF]), .b_i(s1_b_q[HALF-1:0]), .p_o(hl_d)
    );
    vedic_mul_unsigned_nbits #(.N(HALF)) u_mul_hh (
        .a_i(s1_a_q[WIDTH-1:HALF]), .b_i(s1_b_q[WIDTH-1:HALF]), .p_o(hh_d)
    );

    always_comb begin
        mid   = {1'b0, lh_q} + {1'b0, hl_q};
        z_mag = {hh_q, ll_q} + ({{(WIDTH-1){1'b0}}, mid} << HALF);
`ifdef VEDIC_MUL_SIGNED_EN
        s3_z_d = s2_neg_q ? -z_mag : z_mag;
`else
        s3_z_d = z_mag;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            ll_q       <= '0;
            lh_q       <= '0;
            hl_q       <= '0;
            hh_q       <= '0;
            s2_tag_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_z_q     <= '0;
            s3_tag_q   <= '0;
`ifdef VEDIC_MUL_SIGNED_EN
            s1_neg_q   <= 1'b0;
            s2_neg_q   <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid_q <= in_valid;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= in_tag;
            s2_valid_q <= s1_valid_q;
            ll_q       <= ll_d;
            lh_q       <= lh_d;
            hl_q       <= hl_d;
            hh_q       <= hh_d;
            s2_tag_q   <= s1_tag_q;
            s3_valid_q <= s2_valid_q;
            s3_z_q     <= s3_z_d;
            s3_tag_q   <= s2_tag_q;
`ifdef VEDIC_MUL_SIGNED_EN
            s1_neg_q   <= s1_neg_d;
            s2_neg_q   <= s1_neg_q;
`endif
        end
    end

    assign out_valid = s3_valid_q;
    assign out_z     = s3_z_q;
    assign out_tag   = s3_tag_q;

endmodule
